rv32i_mem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the CPU fetch stage (IF port) and the load/store stage (DM port).
- Owns the memory-side request/grant/response handshake and allows one outstanding transaction.
- Data port has priority, with a starvation guard for fetch and a response timeout that reports a bus error.
- Sits between the CPU core and the memory model instantiated in the CPU top.

---
 rtl/rv32i_mem_arbiter_pkg.sv | 31 +++
 rtl/rv32i_arb_timer.sv | 33 +++
 rtl/rv32i_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared encodings and types for the IF/DM memory arbiter.
// Holds FSM states, owner codes, the memory command bundle and the error-data default.
package rv32i_mem_arbiter_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   typedef struct packed {
      logic            we;
      logic [3:0]      be;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } mem_cmd_t;

   // Fetches are always full-word reads.
   function automatic mem_cmd_t fetch_cmd(input logic [XLEN-1:0] addr);
      fetch_cmd = '{we: 1'b0, be: 4'hF, addr: addr, wdata: '0};
   endfunction

endpackage

// File: rtl/rv32i_arb_timer.sv
// Loadable saturating up-counter with clear, enable and terminal-count flag.
// Used by the arbiter both as the fetch-starvation counter and the response timeout timer.
module rv32i_arb_timer #(
   parameter int LIMIT = 4,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   // Clear beats load beats count; the count never passes LIMIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (load_val > W'(LIMIT)) ? W'(LIMIT) : load_val;
      end else if (en && (cnt != W'(LIMIT))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == W'(LIMIT));

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between CPU fetch (IF) and load/store (DM) ports.
// One outstanding transaction, DM priority with fetch starvation guard, response timeout.
module rv32i_mem_arbiter
   import rv32i_mem_arbiter_pkg::*;
#(
   parameter int              STARVE_LIMIT = 4,
   parameter int              TIMEOUT      = 16,
   parameter logic [XLEN-1:0] ERR_DATA     = ERR_DATA_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [XLEN-1:0] if_rdata,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [3:0]      dm_be,
   input  logic [XLEN-1:0] dm_addr,
   input  logic [XLEN-1:0] dm_wdata,
   output logic            dm_gnt,
   output logic            dm_rvalid,
   output logic [XLEN-1:0] dm_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            bus_err
);

   state_t   state;
   owner_t   owner;
   mem_cmd_t cmd_q;
   mem_cmd_t arb_cmd;

   logic starve_tc;
   logic tmo_tc;
   logic if_wins;
   logic arb_now;
   logic resp;
   logic abort;

   // A new transaction may start from IDLE or straight out of a completing WAIT.
   assign if_wins = if_req && (!dm_req || starve_tc);
   assign arb_now = (if_req || dm_req) &&
                    ((state == ST_IDLE) || ((state == ST_WAIT) && mem_rvalid));

   // NOTE: arb_cmd gets a full default before the override so no latch is inferred.
   always_comb begin
      arb_cmd = fetch_cmd(if_addr);
      if (!if_wins) begin
         arb_cmd = '{we: dm_we, be: dm_be, addr: dm_addr, wdata: dm_wdata};
      end
   end

   rv32i_arb_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .reset    (reset),
      .clr      (!if_req || (arb_now && if_wins)),
      .en       (arb_now && !if_wins && if_req),
      .load     (1'b0),
      .load_val ('0),
      .tc       (starve_tc)
   );

   rv32i_arb_timer #(.LIMIT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr      (state != ST_WAIT),
      .en       (state == ST_WAIT),
      .load     (1'b0),
      .load_val ('0),
      .tc       (tmo_tc)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         owner   <= OWN_IF;
         mem_req <= 1'b0;
         cmd_q   <= '0;
      end else if (arb_now) begin
         state   <= ST_ISSUE;
         owner   <= if_wins ? OWN_IF : OWN_DM;
         mem_req <= 1'b1;
         cmd_q   <= arb_cmd;
      end else begin
         case (state)
            ST_ISSUE: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid || tmo_tc) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_we    = cmd_q.we;
   assign mem_be    = cmd_q.be;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.wdata;

   // A real response always wins over the timeout in the same cycle.
   assign resp    = (state == ST_WAIT) && mem_rvalid;
   assign abort   = (state == ST_WAIT) && !mem_rvalid && tmo_tc;
   assign bus_err = abort;

   assign if_gnt    = (state == ST_ISSUE) && mem_gnt && (owner == OWN_IF);
   assign dm_gnt    = (state == ST_ISSUE) && mem_gnt && (owner == OWN_DM);
   assign if_rvalid = (resp || abort) && (owner == OWN_IF);
   assign dm_rvalid = (resp || abort) && (owner == OWN_DM);
   assign if_rdata  = !if_rvalid ? '0 : (resp ? mem_rdata : ERR_DATA);
   assign dm_rdata  = !dm_rvalid ? '0 : (resp ? mem_rdata : ERR_DATA);

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: behavioural memory, scoreboard queues per port.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rv32i_mem_arbiter;

   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        dm_req = 1'b0, dm_we = 1'b0;
   logic [3:0]  dm_be = '0;
   logic [31:0] dm_addr = '0, dm_wdata = '0;
   logic        dm_gnt, dm_rvalid;
   logic [31:0] dm_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        bus_err;

   rv32i_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dm_q[$];
   logic        grant_log[$];   // 0 = IF, 1 = DM
   int          grant_cyc[$];
   logic [68:0] hs_log[$];      // {we, be, addr, wdata} at each grant

   logic [31:0] memarr [0:1023];
   logic [31:0] shadow [0:1023];

   int          gnt_delay = 0;
   logic        drop_resp = 1'b0;
   logic        inject_rvalid = 1'b0;
   logic        hs = 1'b0;
   logic [68:0] hs_cmd = '0;
   int          stall = 0;

   int          buserr_cnt = 0;
   int          last_dm_rvalid_cyc = 0;
   int          req_rise_cyc = 0;
   logic        prev_req = 1'b0;
   logic [68:0] req_snap = '0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Behavioural memory: grant after gnt_delay cycles of mem_req, respond the cycle after grant.
   always begin
      @(posedge clk);
      #1;
      if (reset) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; stall = 0;
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (hs) begin
            if (hs_cmd[68]) begin
               for (int b = 0; b < 4; b++)
                  if (hs_cmd[64+b]) memarr[hs_cmd[43:34]][8*b +: 8] = hs_cmd[8*b +: 8];
            end
            if (!drop_resp) begin
               mem_rvalid = 1'b1;
               mem_rdata  = hs_cmd[68] ? 32'h0 : memarr[hs_cmd[43:34]];
            end
         end
         if (inject_rvalid) begin
            mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; inject_rvalid = 1'b0;
         end
         mem_gnt = 1'b0;
         if (mem_req) begin
            if (stall >= gnt_delay) begin mem_gnt = 1'b1; stall = 0; end
            else stall++;
         end else begin
            stall = 0;
         end
      end
   end

   // Monitor: scoreboard pops on responses, protocol checks every cycle.
   always @(negedge clk) begin
      hs     = mem_req & mem_gnt;
      hs_cmd = {mem_we, mem_be, mem_addr, mem_wdata};
      if (reset) begin
         prev_req = 1'b0;
      end else begin
         if (if_rvalid) begin
            if (exp_if_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
            else check("if_rdata", if_rdata, exp_if_q.pop_front());
         end else check("if_rdata_zero", if_rdata, 0);
         if (dm_rvalid) begin
            last_dm_rvalid_cyc = cyc;
            if (exp_dm_q.size() == 0) check("dm_rvalid_unexpected", 1, 0);
            else check("dm_rdata", dm_rdata, exp_dm_q.pop_front());
         end else check("dm_rdata_zero", dm_rdata, 0);
         check("rvalid_excl", if_rvalid & dm_rvalid, 0);
         check("gnt_excl", if_gnt & dm_gnt, 0);
         check("gnt_vs_mem", if_gnt | dm_gnt, mem_req & mem_gnt);
         check("buserr_has_rvalid", bus_err & ~(if_rvalid | dm_rvalid), 0);
         if (bus_err) buserr_cnt++;
         if (if_gnt | dm_gnt) begin
            grant_log.push_back(dm_gnt);
            grant_cyc.push_back(cyc);
            hs_log.push_back(hs_cmd);
         end
         if (mem_req && prev_req) check("mem_stable", hs_cmd, req_snap);
         else if (mem_req) begin req_snap = hs_cmd; req_rise_cyc = cyc; end
         prev_req = mem_req;
      end
   end

   task automatic if_fetch(input logic [31:0] addr);
      bit got = 1'b0;
      exp_if_q.push_back(shadow[addr[11:2]]);
      if_req = 1'b1; if_addr = addr;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk); got = if_gnt;
         @(posedge clk); #1;
      end
      check("if_gnt_seen", got, 1);
      if_req = 1'b0;
   endtask

   // mode 0: normal scoreboard entry, 1: expect ERR_DATA, 2: no response expected
   task automatic dm_access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata, input int mode);
      bit got = 1'b0;
      if (mode == 1) exp_dm_q.push_back(ERR);
      else if (mode == 0) begin
         if (we) begin
            exp_dm_q.push_back(32'h0);
            for (int b = 0; b < 4; b++)
               if (be[b]) shadow[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
         end else exp_dm_q.push_back(shadow[addr[11:2]]);
      end
      dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk); got = dm_gnt;
         @(posedge clk); #1;
      end
      check("dm_gnt_seen", got, 1);
      dm_req = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && (exp_if_q.size() + exp_dm_q.size()) != 0; i++) @(posedge clk);
      #1;
      check("drain", exp_if_q.size() + exp_dm_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check(tag, {if_rvalid, dm_rvalid, bus_err}, 0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int n, g, b0, gcyc;
      for (int i = 0; i < 1024; i++) begin
         memarr[i] = 32'h1000_0000 | (i << 2);
         shadow[i] = 32'h1000_0000 | (i << 2);
      end
      memarr[1] = 32'h0050_0093;
      shadow[1] = 32'h0050_0093;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_if_outputs", {if_gnt, if_rvalid, if_rdata, bus_err}, 0);
      check("reset_dm_outputs", {dm_gnt, dm_rvalid, dm_rdata}, 0);
      check("reset_mem_outputs", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of WAIT for a DM load
      drop_resp = 1'b1;
      dm_access(1'b0, 4'hF, 32'h100, 32'h0, 2);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_dm_rvalid", dm_rvalid, 0);
      check("rst_bus_err", bus_err, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      drop_resp = 1'b0;
      inject_rvalid = 1'b1;
      check_quiet("late_rvalid_after_reset", 20);
      check("no_timeout_after_reset", buserr_cnt, 0);
      if_fetch(32'h0);
      wait_drain();

      // Lone fetch
      n = grant_log.size();
      if_fetch(32'h4);
      wait_drain();
      check("lone_grants", grant_log.size() - n, 1);
      if (grant_log.size() > n) begin
         check("lone_owner", grant_log[n], 0);
         check("lone_mem_cmd", hs_log[n], {1'b0, 4'hF, 32'h4, 32'h0});
      end

      // Contention: DM store first, IF back-to-back on the DM ack cycle
      n = grant_log.size();
      fork
         if_fetch(32'h8);
         dm_access(1'b1, 4'b0011, 32'h200, 32'hCAFE_F00D, 0);
      join
      wait_drain();
      check("contention_grants", grant_log.size() - n, 2);
      if (grant_log.size() >= n + 2) begin
         check("contention_first_dm", grant_log[n], 1);
         check("contention_dm_cmd", hs_log[n], {1'b1, 4'b0011, 32'h200, 32'hCAFE_F00D});
         check("contention_then_if", grant_log[n+1], 0);
         check("contention_if_cmd", hs_log[n+1], {1'b0, 4'hF, 32'h8, 32'h0});
         check("contention_b2b_spacing", grant_cyc[n+1] - grant_cyc[n], 2);
      end
      dm_access(1'b0, 4'hF, 32'h200, 32'h0, 0);
      wait_drain();

      // Starvation: both held; expect DDDDI DDDDI
      n = grant_log.size();
      g = 0;
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h20; dm_wdata = '0;
      for (int i = 0; i < 200 && g < 10; i++) begin
         @(negedge clk);
         if (if_gnt) begin exp_if_q.push_back(shadow[4]); g++; end
         if (dm_gnt) begin exp_dm_q.push_back(shadow[8]); g++; end
      end
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;
      wait_drain();
      check("starve_grants", grant_log.size() - n, 10);
      if (grant_log.size() >= n + 10) begin
         for (int k = 0; k < 10; k++)
            check($sformatf("starve_order_%0d", k), grant_log[n+k], (k % 5 == 4) ? 1'b0 : 1'b1);
      end

      // Timeout on a DM load that never gets a response
      drop_resp = 1'b1;
      b0 = buserr_cnt;
      dm_access(1'b0, 4'hF, 32'h300, 32'h0, 1);
      gcyc = grant_cyc[$];
      wait_drain();
      check("timeout_latency", last_dm_rvalid_cyc - gcyc, 17);
      check("timeout_buserr_once", buserr_cnt - b0, 1);
      check("timeout_mem_req_low", mem_req, 0);
      inject_rvalid = 1'b1;
      check_quiet("late_rvalid_after_abort", 4);
      drop_resp = 1'b0;

      // Memory stall: mem_gnt low for 5 cycles
      gnt_delay = 5;
      n = grant_log.size();
      dm_access(1'b1, 4'hF, 32'h40, 32'h0BAD_F00D, 0);
      wait_drain();
      check("stall_grants", grant_log.size() - n, 1);
      if (grant_log.size() > n) check("stall_gnt_delay", grant_cyc[n] - req_rise_cyc, 5);
      dm_access(1'b0, 4'hF, 32'h40, 32'h0, 0);
      if_fetch(32'h4);
      wait_drain();
      gnt_delay = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
